// File: rtl/cnn_chan_split_4_pkg.sv
// Shared defaults, derived sizes and the counter-width helper for the
// four-lane channel splitter.
package cnn_chan_split_4_pkg;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_IMAGE_WIDTH    = 612;
  localparam int DEF_IMAGE_HEIGHT   = 612;
  localparam int DEF_CHANNEL_NUM_IN = 64;
  localparam int DEF_KERNEL         = 3;

  localparam int LANES  = 4;
  localparam int LANE_W = 2;

  typedef logic [LANE_W-1:0] lane_t;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int Q         = DEF_CHANNEL_NUM_IN / LANES;
  localparam int CH_CNT_W  = cnt_w(DEF_CHANNEL_NUM_IN);
  localparam int PIX_CNT_W = cnt_w(DEF_IMAGE_WIDTH * DEF_IMAGE_HEIGHT);
  localparam int WGT_CNT_W = cnt_w(DEF_KERNEL * DEF_KERNEL * Q);

endpackage

// File: rtl/cnn_chan_split_4_if.sv
// Stream bundle between the previous layer (master) and the splitter (slave).
// Valid-only handshake: a word is taken on every rising edge its valid is high;
// there is no ready, so the consumer must accept every valid word.
interface cnn_chan_split_4_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] pxl_in;
  logic                  valid_weight_in;
  logic [DATA_WIDTH-1:0] weight_in;

  logic                  valid_out1;
  logic                  valid_out2;
  logic                  valid_out3;
  logic                  valid_out4;
  logic [DATA_WIDTH-1:0] pxl_out1;
  logic [DATA_WIDTH-1:0] pxl_out2;
  logic [DATA_WIDTH-1:0] pxl_out3;
  logic [DATA_WIDTH-1:0] pxl_out4;

  logic                  valid_weight_out1;
  logic                  valid_weight_out2;
  logic                  valid_weight_out3;
  logic                  valid_weight_out4;
  logic [DATA_WIDTH-1:0] weight_out1;
  logic [DATA_WIDTH-1:0] weight_out2;
  logic [DATA_WIDTH-1:0] weight_out3;
  logic [DATA_WIDTH-1:0] weight_out4;

  logic                  frame_done;

  modport master (
    output valid_in, pxl_in, valid_weight_in, weight_in,
    input  valid_out1, valid_out2, valid_out3, valid_out4,
    input  pxl_out1, pxl_out2, pxl_out3, pxl_out4,
    input  valid_weight_out1, valid_weight_out2, valid_weight_out3, valid_weight_out4,
    input  weight_out1, weight_out2, weight_out3, weight_out4,
    input  frame_done
  );

  modport slave (
    input  valid_in, pxl_in, valid_weight_in, weight_in,
    output valid_out1, valid_out2, valid_out3, valid_out4,
    output pxl_out1, pxl_out2, pxl_out3, pxl_out4,
    output valid_weight_out1, valid_weight_out2, valid_weight_out3, valid_weight_out4,
    output weight_out1, weight_out2, weight_out3, weight_out4,
    output frame_done
  );
endinterface

// File: rtl/cnn_lane_buf.sv
// One-quarter-pixel lane buffer: single write port, registered read port.
// Storage is not reset; only the read register is, so outputs start at zero.
module cnn_lane_buf
  import cnn_chan_split_4_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = cnt_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/cnn_chan_split_4.sv
// Splits a channel-interleaved pixel stream into four lockstep lane streams
// and deals a serial weight stream block-wise across the four lanes.
module cnn_chan_split_4
  import cnn_chan_split_4_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int IMAGE_WIDTH    = DEF_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT   = DEF_IMAGE_HEIGHT,
  parameter int CHANNEL_NUM_IN = DEF_CHANNEL_NUM_IN,
  parameter int KERNEL         = DEF_KERNEL
) (
  input  logic               clk,
  input  logic               reset,
  cnn_chan_split_4_if.slave  bus
);

  localparam int LQ        = CHANNEL_NUM_IN / LANES;
  localparam int WORD_W    = cnt_w(LQ);
  localparam int PIX_TOTAL = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int PIX_W     = cnt_w(PIX_TOTAL);
  localparam int WGT_BLK   = KERNEL * KERNEL * LQ;
  localparam int WGT_W     = cnt_w(WGT_BLK);

  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(LQ - 1);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(PIX_TOTAL - 1);
  localparam logic [WGT_W-1:0]  WGT_LAST  = WGT_W'(WGT_BLK - 1);
  localparam lane_t             LANE_LAST = lane_t'(LANES - 1);

  // chan_cnt is kept split as {lane_cnt, word_cnt}: lane = chan / Q, j = chan mod Q.
  logic [WORD_W-1:0] word_cnt;
  lane_t             lane_cnt;
  logic [PIX_W-1:0]  pix_cnt;

  logic                  pix_valid;
  logic [DATA_WIDTH-1:0] pix_lane4;
  logic                  frame_pulse;
  logic [DATA_WIDTH-1:0] lane_rd [LANES-1];

  logic word_wrap;
  logic in_lane4;
  logic pix_wrap;

  assign word_wrap = bus.valid_in && (word_cnt == WORD_LAST);
  assign in_lane4  = (lane_cnt == LANE_LAST);
  assign pix_wrap  = word_wrap && in_lane4;

  always_ff @(posedge clk) begin
    if (reset) begin
      word_cnt    <= '0;
      lane_cnt    <= '0;
      pix_cnt     <= '0;
      pix_valid   <= 1'b0;
      pix_lane4   <= '0;
      frame_pulse <= 1'b0;
    end else begin
      if (bus.valid_in) begin
        if (word_wrap) begin
          word_cnt <= '0;
          lane_cnt <= lane_cnt + lane_t'(1);
        end else begin
          word_cnt <= word_cnt + WORD_W'(1);
        end
      end
      if (pix_wrap) begin
        pix_cnt <= (pix_cnt == PIX_LAST) ? '0 : pix_cnt + PIX_W'(1);
      end
      pix_valid <= bus.valid_in && in_lane4;
      if (bus.valid_in && in_lane4) begin
        pix_lane4 <= bus.pxl_in;
      end
      frame_pulse <= pix_wrap && (pix_cnt == PIX_LAST);
    end
  end

  // Lane k's word j is read while lane-4 word j arrives, always before the
  // next pixel can overwrite it, so one buffer per lane is enough.
  for (genvar k = 0; k < LANES - 1; k++) begin : g_lane
    cnn_lane_buf #(
      .DEPTH      (LQ),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_W     (WORD_W)
    ) u_buf (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (bus.valid_in && (lane_cnt == lane_t'(k))),
      .wr_addr (word_cnt),
      .wr_data (bus.pxl_in),
      .rd_en   (bus.valid_in && in_lane4),
      .rd_addr (word_cnt),
      .rd_data (lane_rd[k])
    );
  end

  assign bus.valid_out1 = pix_valid;
  assign bus.valid_out2 = pix_valid;
  assign bus.valid_out3 = pix_valid;
  assign bus.valid_out4 = pix_valid;
  assign bus.pxl_out1   = lane_rd[0];
  assign bus.pxl_out2   = lane_rd[1];
  assign bus.pxl_out3   = lane_rd[2];
  assign bus.pxl_out4   = pix_lane4;
  assign bus.frame_done = frame_pulse;

  // Weight dealer: fully independent of the pixel path.
  logic [WGT_W-1:0]      wgt_cnt;
  lane_t                 wgt_lane;
  logic [LANES-1:0]      wgt_valid;
  logic [DATA_WIDTH-1:0] wgt_data [LANES];

  always_ff @(posedge clk) begin
    if (reset) begin
      wgt_cnt   <= '0;
      wgt_lane  <= '0;
      wgt_valid <= '0;
      for (int k = 0; k < LANES; k++) begin
        wgt_data[k] <= '0;
      end
    end else begin
      wgt_valid <= '0;
      if (bus.valid_weight_in) begin
        wgt_valid[wgt_lane] <= 1'b1;
        wgt_data[wgt_lane]  <= bus.weight_in;
        if (wgt_cnt == WGT_LAST) begin
          wgt_cnt  <= '0;
          wgt_lane <= wgt_lane + lane_t'(1);
        end else begin
          wgt_cnt <= wgt_cnt + WGT_W'(1);
        end
      end
    end
  end

  assign bus.valid_weight_out1 = wgt_valid[0];
  assign bus.valid_weight_out2 = wgt_valid[1];
  assign bus.valid_weight_out3 = wgt_valid[2];
  assign bus.valid_weight_out4 = wgt_valid[3];
  assign bus.weight_out1       = wgt_data[0];
  assign bus.weight_out2       = wgt_data[1];
  assign bus.weight_out3       = wgt_data[2];
  assign bus.weight_out4       = wgt_data[3];

endmodule

// File: tb/tb_cnn_chan_split_4.sv
// Self-checking bench for cnn_chan_split_4 on a 2x2 image, 64 channels, 3x3 kernel.
module tb_cnn_chan_split_4;

  localparam int W    = 32;
  localparam int CH   = 64;
  localparam int Q    = CH / 4;
  localparam int IW   = 2;
  localparam int IH   = 2;
  localparam int K    = 3;
  localparam int NPF  = IW * IH;
  localparam int WBLK = K * K * Q;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cnn_chan_split_4_if #(.DATA_WIDTH(W)) bus ();

  cnn_chan_split_4 #(
    .DATA_WIDTH     (W),
    .IMAGE_WIDTH    (IW),
    .IMAGE_HEIGHT   (IH),
    .CHANNEL_NUM_IN (CH),
    .KERNEL         (K)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // scoreboard
  typedef struct packed {
    logic [4*W-1:0] data;
    logic           frame;
    int             due;
  } beat_t;

  typedef struct packed {
    logic [1:0]   lane;
    logic [W-1:0] data;
    int           due;
  } wbeat_t;

  beat_t  exp_q[$];
  wbeat_t wexp_q[$];

  int total = 0;
  int bad = 0;
  int beat_cnt = 0;
  int frame_cnt = 0;
  int pix_idx = 0;
  int wgt_idx = 0;

  task automatic check(input string name, input bit ok,
                       input logic [4*W:0] act, input logic [4*W:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0]     pv;
    logic [3:0]     wv;
    logic [4*W-1:0] act;
    beat_t          e;
    wbeat_t         we;
    logic [1:0]     wl;
    logic [W-1:0]   wd;
    if (!reset) begin
      pv  = {bus.valid_out4, bus.valid_out3, bus.valid_out2, bus.valid_out1};
      act = {bus.pxl_out1, bus.pxl_out2, bus.pxl_out3, bus.pxl_out4};
      if (pv != 4'b0000) begin
        beat_cnt++;
        if (bus.frame_done) frame_cnt++;
        check("valid_lockstep", pv == 4'b1111, 129'(pv), 129'(4'b1111));
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1'b0, {act, bus.frame_done}, '0);
        end else begin
          e = exp_q.pop_front();
          check("beat", act == e.data && bus.frame_done == e.frame && e.due == cyc,
                {act, bus.frame_done}, {e.data, e.frame});
        end
      end else begin
        if (bus.frame_done) begin
          frame_cnt++;
          check("stray_frame_done", 1'b0, 129'(1), 129'(0));
        end
        if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
          e = exp_q.pop_front();
          check("missed_beat", 1'b0, '0, {e.data, e.frame});
        end
      end

      wv = {bus.valid_weight_out4, bus.valid_weight_out3,
            bus.valid_weight_out2, bus.valid_weight_out1};
      if ($countones(wv) > 1) begin
        check("weight_one_hot", 1'b0, 129'(wv), '0);
      end else if (wv != 4'b0000) begin
        wl = wv[0] ? 2'd0 : wv[1] ? 2'd1 : wv[2] ? 2'd2 : 2'd3;
        wd = wv[0] ? bus.weight_out1 : wv[1] ? bus.weight_out2 :
             wv[2] ? bus.weight_out3 : bus.weight_out4;
        if (wexp_q.size() == 0) begin
          check("unexpected_weight", 1'b0, 129'({wl, wd}), '0);
        end else begin
          we = wexp_q.pop_front();
          check("weight", wl == we.lane && wd == we.data && we.due == cyc,
                129'({wl, wd}), 129'({we.lane, we.data}));
        end
      end else if (wexp_q.size() != 0 && wexp_q[0].due <= cyc) begin
        we = wexp_q.pop_front();
        check("missed_weight", 1'b0, '0, 129'({we.lane, we.data}));
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs_zero(input string name);
    logic [4*W:0] v;
    v = {bus.pxl_out1 | bus.pxl_out2 | bus.pxl_out3 | bus.pxl_out4,
         bus.weight_out1 | bus.weight_out2 | bus.weight_out3 | bus.weight_out4,
         bus.valid_out1, bus.valid_out2, bus.valid_out3, bus.valid_out4,
         bus.valid_weight_out1, bus.valid_weight_out2, bus.valid_weight_out3,
         bus.valid_weight_out4, bus.frame_done};
    check(name, v == '0, v, '0);
  endtask

  task automatic do_reset();
    bus.valid_in        = 1'b0;
    bus.valid_weight_in = 1'b0;
    bus.pxl_in          = '0;
    bus.weight_in       = '0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_outs_zero("reset_outs");
    exp_q.delete();
    wexp_q.delete();
    pix_idx   = 0;
    wgt_idx   = 0;
    beat_cnt  = 0;
    frame_cnt = 0;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_outs_zero("reset_outs_release");
    @(negedge clk);
    check_outs_zero("reset_outs_after");
    tick();
  endtask

  task automatic drive_pixels(input int npix, input int nch, input int gap_pct);
    beat_t b;
    int j;
    for (int p = 0; p < npix; p++) begin
      for (int ch = 0; ch < nch; ch++) begin
        while ($urandom_range(99) < gap_pct) begin
          bus.valid_in = 1'b0;
          tick();
        end
        bus.valid_in = 1'b1;
        bus.pxl_in   = W'(100 * p + ch);
        if (ch >= 3 * Q) begin
          j = ch - 3 * Q;
          b.data  = {W'(100 * p + j), W'(100 * p + Q + j),
                     W'(100 * p + 2 * Q + j), W'(100 * p + 3 * Q + j)};
          b.frame = ((pix_idx % NPF) == NPF - 1) && (j == Q - 1);
          b.due   = cyc + 1;
          exp_q.push_back(b);
        end
        tick();
      end
      if (nch == CH) pix_idx++;
    end
    bus.valid_in = 1'b0;
  endtask

  task automatic drive_weights(input int n, input int gap_pct);
    wbeat_t b;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        bus.valid_weight_in = 1'b0;
        tick();
      end
      bus.valid_weight_in = 1'b1;
      bus.weight_in       = W'(i);
      b.lane = 2'((wgt_idx / WBLK) % 4);
      b.data = W'(i);
      b.due  = cyc + 1;
      wexp_q.push_back(b);
      wgt_idx++;
      tick();
    end
    bus.valid_weight_in = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && (exp_q.size() != 0 || wexp_q.size() != 0); i++) tick();
    check(name, exp_q.size() == 0 && wexp_q.size() == 0,
          129'(exp_q.size() + wexp_q.size()), '0);
  endtask

  // table-driven scenarios
  typedef struct {
    int npix;
    int gap_pct;
    int nwgt;
    int wgap_pct;
    int exp_beats;
    int exp_frames;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{npix: 1, gap_pct: 0,  nwgt: 0,   wgap_pct: 0,  exp_beats: 16, exp_frames: 0};
    vecs[1] = '{npix: 1, gap_pct: 50, nwgt: 0,   wgap_pct: 0,  exp_beats: 16, exp_frames: 0};
    vecs[2] = '{npix: 3, gap_pct: 0,  nwgt: 577, wgap_pct: 0,  exp_beats: 48, exp_frames: 0};
    vecs[3] = '{npix: 5, gap_pct: 0,  nwgt: 0,   wgap_pct: 0,  exp_beats: 80, exp_frames: 1};
    vecs[4] = '{npix: 2, gap_pct: 30, nwgt: 300, wgap_pct: 40, exp_beats: 32, exp_frames: 0};

    for (int v = 0; v < 5; v++) begin
      do_reset();
      fork
        drive_pixels(vecs[v].npix, CH, vecs[v].gap_pct);
        drive_weights(vecs[v].nwgt, vecs[v].wgap_pct);
      join
      drain("drain");
      check("beat_count", beat_cnt == vecs[v].exp_beats,
            129'(beat_cnt), 129'(vecs[v].exp_beats));
      check("frame_count", frame_cnt == vecs[v].exp_frames,
            129'(frame_cnt), 129'(vecs[v].exp_frames));
    end

    // reset after 30 channels of a pixel and 50 weights, then a fresh pixel
    do_reset();
    fork
      drive_pixels(1, 30, 0);
      drive_weights(50, 0);
    join
    tick();
    drain("drain_partial");
    check("partial_no_beats", beat_cnt == 0, 129'(beat_cnt), '0);
    do_reset();
    fork
      drive_pixels(1, CH, 0);
      drive_weights(150, 0);
    join
    drain("drain_after_reset");
    check("beat_count_after_reset", beat_cnt == Q, 129'(beat_cnt), 129'(Q));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
